// File: rtl/nn_pkg.sv
// nn_pkg: shared FSM states, index-width helper and Q-format constants for the neuron datapath.
package nn_pkg;
  typedef enum logic [2:0] {LOAD, CLEAR, FEED, FLUSH, CAPTURE} state_t;
  localparam int Q_WIDTH = 8;
  localparam int Q_INT_BITS = 2;
  localparam int Q_FRAC_BITS = Q_WIDTH - Q_INT_BITS;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/weight_bank.sv
// weight_bank: DEPTH x WIDTH weight register file, one write port, combinational read.
module weight_bank
  import nn_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int DEPTH = 12,
  localparam int AW = idx_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  assign o_rd_data = r_mem[i_rd_addr];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    else if (i_wr_en && int'(i_wr_addr) < DEPTH)
      r_mem[i_wr_addr] <= i_wr_data;
endmodule

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: buffers one activation vector and drives MAC clear/feed/flush per neuron,
// capturing each neuron's result onto a ready/valid stream in index order.
module neuron_sequencer
  import nn_pkg::*;
#(
  parameter int WIDTH = Q_WIDTH,
  parameter int INPUTS = 3,
  parameter int NEURONS = 4,
  localparam int AW = idx_w(NEURONS * INPUTS),
  localparam int NW = idx_w(NEURONS),
  localparam int KW = idx_w(INPUTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             w_wr_en,
  input  logic [AW-1:0]    w_addr,
  input  logic [WIDTH-1:0] w_data,
  output logic             mac_clr,
  output logic             mac_en,
  output logic [WIDTH-1:0] mac_a,
  output logic [WIDTH-1:0] mac_b,
  input  logic [WIDTH-1:0] mac_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [NW-1:0]    out_idx,
  output logic             busy
);
  state_t           r_state;
  logic [KW-1:0]    r_k;
  logic [NW-1:0]    r_n;
  logic [WIDTH-1:0] r_act [INPUTS];
  logic [WIDTH-1:0] w_weight;
  logic [AW-1:0]    w_rd_addr;
  logic             w_issue;
  assign in_ready  = r_state == LOAD;
  assign w_rd_addr = AW'(r_n) * AW'(INPUTS) + AW'(r_k);
  // r_k == INPUTS marks that every operand has been issued and the flush is next
  assign w_issue   = r_k < KW'(INPUTS);
  weight_bank #(.WIDTH(WIDTH), .DEPTH(NEURONS * INPUTS)) u_bank (
    .clk(clk), .reset(reset), .i_wr_en(w_wr_en), .i_wr_addr(w_addr), .i_wr_data(w_data),
    .i_rd_addr(w_rd_addr), .o_rd_data(w_weight)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= LOAD;
      r_k <= '0;
      r_n <= '0;
      for (int i = 0; i < INPUTS; i++) r_act[i] <= '0;
      mac_clr <= 1'b0;
      mac_en <= 1'b0;
      mac_a <= '0;
      mac_b <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_idx <= '0;
      busy <= 1'b0;
    end else begin
      mac_clr <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (r_state)
        LOAD: if (in_valid) begin
          r_act[r_k] <= in_data;
          busy <= 1'b1;
          r_k <= (r_k == KW'(INPUTS - 1)) ? '0 : r_k + KW'(1);
          if (r_k == KW'(INPUTS - 1)) begin
            r_n <= '0;
            mac_clr <= 1'b1;
            r_state <= CLEAR;
          end
        end
        CLEAR, FEED: begin
          mac_en <= 1'b1;
          mac_a <= w_issue ? r_act[r_k] : '0;
          mac_b <= w_issue ? w_weight : '0;
          r_k <= w_issue ? r_k + KW'(1) : r_k;
          r_state <= w_issue ? FEED : FLUSH;
        end
        FLUSH: begin
          mac_en <= 1'b0;
          r_state <= CAPTURE;
        end
        CAPTURE: if (!out_valid || out_ready) begin
          out_data <= mac_out;
          out_idx <= r_n;
          out_valid <= 1'b1;
          r_k <= '0;
          if (r_n == NW'(NEURONS - 1)) begin
            busy <= 1'b0;
            r_state <= LOAD;
          end else begin
            r_n <= r_n + NW'(1);
            mac_clr <= 1'b1;
            r_state <= CLEAR;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
endmodule

// File: doc/neuron_sequencer.md
# neuron_sequencer

Upstream control stage for the multiplier-accumulator (MAC) unit. It buffers one input activation vector, holds a weight bank for NEURONS neurons, and drives the MAC operand/enable/clear inputs once per neuron. It also issues the zero-operand flush cycle the MAC's registered output needs, captures each neuron's clamped, ReLU'd result, and presents it on a ready/valid result stream. One vector in gives NEURONS results out, in neuron-index order.

## Interface
- WIDTH, 8: signed fixed-point width of activations, weights, and results (format Q2.6 at default).
- INPUTS, 3: activations per vector. This is the number of accumulations per neuron.
- NEURONS, 4: neurons evaluated per vector.

- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  activation stream valid.
- in_ready  out  1  activation stream ready.
- in_data  in  WIDTH  signed activation.
- w_wr_en  in  1  weight write strobe.
- w_addr  in  $clog2(NEURONS*INPUTS)  weight address = neuron*INPUTS + k.
- w_data  in  WIDTH  signed weight.
- mac_clr  out  1  accumulator clear pulse to the MAC.
- mac_en  out  1  MAC enable.
- mac_a  out  WIDTH  activation operand.
- mac_b  out  WIDTH  weight operand.
- mac_out  in  WIDTH  MAC registered result.
- out_valid  out  1  result valid.
- out_ready  in  1  result ready.
- out_data  out  WIDTH  neuron result.
- out_idx  out  $clog2(NEURONS)  neuron index of out_data.
- busy  out  1  high from first activation accepted until last result captured.

## Operation
- Reset values:
  - All mac_* outputs are 0.
  - out_valid, out_data, out_idx, and busy are 0.
  - The weight bank and activation buffer are all 0.
  - State is LOAD. in_ready is 1, decoded as state==LOAD.
- LOAD:
  - Accepts in_data on in_valid&&in_ready into buffer slot k = 0..INPUTS-1.
  - After slot INPUTS-1, sets n=0 and goes to CLEAR.
  - in_ready is 0 in all other states.
- CLEAR: mac_clr=1 for exactly one cycle, mac_en=0. Goes to FEED.
- FEED: INPUTS consecutive cycles with mac_en=1, mac_a=act[k], mac_b=w[n*INPUTS+k], k ascending. Goes to FLUSH.
- FLUSH: one cycle with mac_en=1, mac_a=mac_b=0. This commits the final sum to mac_out. Goes to CAPTURE.
- CAPTURE:
  - mac_en=0. Waits until !out_valid || out_ready.
  - On that condition, loads out_data=mac_out, out_idx=n, out_valid=1.
  - If n==NEURONS-1, goes to LOAD and drops busy. Otherwise increments n and goes to CLEAR.
- Result stream:
  - out_valid holds until out_valid&&out_ready, then clears unless reloaded in the same cycle.
  - Simultaneous accept and capture leaves out_valid=1 with the new data.
- Weights:
  - A write occurs when w_wr_en=1. Writes are accepted in any state and take effect the next cycle.
  - Writes to w_addr >= NEURONS*INPUTS are ignored.
  - Rewriting weights mid-vector is legal. Operands already issued are unaffected.
- Arithmetic: the block does none. mac_out passes verbatim; it is already clamped and non-negative.
- Reset mid-operation returns all state, including the weight bank, to reset values immediately. Any pending result is discarded.

## Timing
- All outputs are registered except in_ready.
- Per neuron, relative to the mac_clr cycle C:
  - feed cycles are C+1..C+INPUTS;
  - the flush cycle is C+INPUTS+1;
  - mac_out is valid in cycle C+INPUTS+2;
  - out_valid rises in cycle C+INPUTS+3 if the slot is free.
- Next neuron's CLEAR follows in the cycle after capture.
- Throughput is INPUTS+3 cycles per neuron when out_ready is held high.
- Vector latency: from the last activation accepted to the first mac_clr is 1 cycle.
- Backpressure: mac_en stays 0 while stalled in CAPTURE, so mac_out is stable.

## Structure
- Shared package `nn_pkg`:
  - state enum (LOAD, CLEAR, FEED, FLUSH, CAPTURE);
  - index-width helper function;
  - Q-format constants (WIDTH, INT_BITS=2).
- Sub-module `weight_bank`: NEURONS*INPUTS×WIDTH register file with asynchronous reset, one write port, and combinational read by address.
- Activation buffer, counters k and n, and the FSM live in the top level.

## Test plan
- Weights for neuron 0 = [64,32,0], activations [64,64,64], out_ready=1 -> out_data=96, out_idx=0 at cycle C+6.
- Neuron 1 weights [-64,-64,-64], activations [64,64,64] -> out_data=0 (ReLU).
- Neuron 2 weights [127,127,127], activations [127,127,127] -> out_data=127 (clamp).
- Hold out_ready=0 for 20 cycles after the first result:
  - out_data and out_idx stay stable;
  - mac_en stays 0 in CAPTURE;
  - on release, results come in idx order 0..3 with none lost.
- Write w_addr=12 (out of range) with w_data=5 -> no weight changes, results unchanged.
- Assert reset during FEED of neuron 2:
  - all outputs return to reset values asynchronously;
  - the next vector completes correctly with freshly written weights.
